// File: rtl/rot_pkg.sv
// Shared constants for the rotation datapath: RGB565 layout, fraction and coordinate widths.
package rot_pkg;

  localparam int unsigned FracW  = 8;
  localparam int unsigned CoordW = 12;
  localparam int unsigned PixW   = 16;

  // RGB565 field positions: R[15:11] G[10:5] B[4:0]
  localparam int unsigned RLsb = 11;
  localparam int unsigned RW   = 5;
  localparam int unsigned GLsb = 5;
  localparam int unsigned GW   = 6;
  localparam int unsigned BLsb = 0;
  localparam int unsigned BW   = 5;

  function automatic logic [PixW-1:0] pack565(input logic [RW-1:0] r,
                                              input logic [GW-1:0] g,
                                              input logic [BW-1:0] b);
    return {r, g, b};
  endfunction

endpackage

// File: rtl/bilerp_chan.sv
// One colour channel of the bilinear interpolator: horizontal blend, vertical blend,
// then round/saturate. Two register stages here; the third (output) register sits in
// the top level so that line/frame sync can be registered alongside the pixel.
module bilerp_chan #(
  parameter int unsigned CHAN_W = 5,
  parameter int unsigned FRAC_W = 8
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [FRAC_W-1:0] iv_fx,
  input  logic [FRAC_W-1:0] iv_fy,
  input  logic [CHAN_W-1:0] iv_c11,
  input  logic [CHAN_W-1:0] iv_c12,
  input  logic [CHAN_W-1:0] iv_c21,
  input  logic [CHAN_W-1:0] iv_c22,
  output logic              o_valid,
  output logic [CHAN_W-1:0] ov_res
);

  localparam int unsigned TopW = CHAN_W + FRAC_W + 1;
  localparam int unsigned AccW = CHAN_W + 2 * FRAC_W + 2;
  localparam logic [FRAC_W:0]   WUnit   = {1'b1, {FRAC_W{1'b0}}};
  localparam logic [AccW-1:0]   Half    = AccW'(1) << (2 * FRAC_W - 1);
  localparam logic [CHAN_W-1:0] ChanMax = '1;

  logic              s1_valid_d, s1_valid_q;
  logic [TopW-1:0]   top_d, top_q;
  logic [TopW-1:0]   bot_d, bot_q;
  logic [FRAC_W-1:0] fy_d, fy_q;
  logic              s2_valid_d, s2_valid_q;
  logic [AccW-1:0]   acc_d, acc_q;
  logic [FRAC_W:0]   wx0, wy0;
  logic [AccW-1:0]   rnd, shifted;

  // S1: horizontal blend of top and bottom rows; fy travels along for S2
  always_comb begin
    wx0        = WUnit - {1'b0, iv_fx};
    top_d      = TopW'(iv_c11) * TopW'(wx0) + TopW'(iv_c12) * TopW'(iv_fx);
    bot_d      = TopW'(iv_c21) * TopW'(wx0) + TopW'(iv_c22) * TopW'(iv_fx);
    fy_d       = iv_fy;
    s1_valid_d = i_valid;
  end

  // S2: vertical blend at full precision
  always_comb begin
    wy0        = WUnit - {1'b0, fy_q};
    acc_d      = AccW'(top_q) * AccW'(wy0) + AccW'(bot_q) * AccW'(fy_q);
    s2_valid_d = s1_valid_q;
  end

  // S3 (combinational): round half-up, drop the 2F fraction bits, clamp to channel max
  always_comb begin
    rnd     = acc_q + Half;
    shifted = rnd >> (2 * FRAC_W);
    ov_res  = (shifted > AccW'(ChanMax)) ? ChanMax : shifted[CHAN_W-1:0];
    o_valid = s2_valid_q;
  end

  // Pipeline registers; data always loads, valid qualifies it
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      s1_valid_q <= 1'b0;
      top_q      <= '0;
      bot_q      <= '0;
      fy_q       <= '0;
      s2_valid_q <= 1'b0;
      acc_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      top_q      <= top_d;
      bot_q      <= bot_d;
      fy_q       <= fy_d;
      s2_valid_q <= s2_valid_d;
      acc_q      <= acc_d;
    end
  end

endmodule

// File: rtl/bilinear_interp.sv
// Bilinear interpolator: aligns request fractions with fetched 2x2 neighbourhoods,
// blends per channel, and emits line/frame sync for the rotated-image writer.
module bilinear_interp
  import rot_pkg::*;
#(
  parameter int unsigned FRAC_W    = rot_pkg::FracW,
  parameter int unsigned FETCH_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  input  logic [FRAC_W-1:0] iv_fx,
  input  logic [FRAC_W-1:0] iv_fy,
  input  logic              i_pix_valid,
  input  logic [PixW-1:0]   iv_b11,
  input  logic [PixW-1:0]   iv_b12,
  input  logic [PixW-1:0]   iv_b21,
  input  logic [PixW-1:0]   iv_b22,
  input  logic [CoordW-1:0] iv_width,
  input  logic [CoordW-1:0] iv_depth,
  output logic              o_valid,
  output logic [PixW-1:0]   ov_pixel,
  output logic              o_hsyn,
  output logic              o_fsyn,
  output logic              o_align_err
);

  localparam int unsigned DlW = 1 + 2 * FRAC_W;

  logic [DlW-1:0]    dl_d [FETCH_LAT];
  logic [DlW-1:0]    dl_q [FETCH_LAT];
  logic [DlW-1:0]    tail;
  logic              tail_valid;
  logic [FRAC_W-1:0] tail_fx, tail_fy;

  logic          r_valid, g_valid, b_valid, chan_valid;
  logic [RW-1:0] r_res;
  logic [GW-1:0] g_res;
  logic [BW-1:0] b_res;
  logic [PixW-1:0] res;

  logic [CoordW-1:0] col_d, col_q, row_d, row_q;
  logic              last_col, last_row;
  logic              valid_d, valid_q, hsyn_d, hsyn_q, fsyn_d, fsyn_q, err_d, err_q;
  logic [PixW-1:0]   pixel_d, pixel_q;

  // Fraction delay line: shifts every cycle so the tail lines up with the fetch strobe
  always_comb begin
    dl_d[0] = {i_req_valid, iv_fx, iv_fy};
    for (int i = 1; i < FETCH_LAT; i++) begin
      dl_d[i] = dl_q[i-1];
    end
  end

  assign tail       = dl_q[FETCH_LAT-1];
  assign tail_valid = tail[DlW-1];
  assign tail_fx    = tail[2*FRAC_W-1:FRAC_W];
  assign tail_fy    = tail[FRAC_W-1:0];

  bilerp_chan #(.CHAN_W(RW), .FRAC_W(FRAC_W)) u_chan_r (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_pix_valid),
    .iv_fx   (tail_fx),
    .iv_fy   (tail_fy),
    .iv_c11  (iv_b11[RLsb +: RW]),
    .iv_c12  (iv_b12[RLsb +: RW]),
    .iv_c21  (iv_b21[RLsb +: RW]),
    .iv_c22  (iv_b22[RLsb +: RW]),
    .o_valid (r_valid),
    .ov_res  (r_res)
  );

  bilerp_chan #(.CHAN_W(GW), .FRAC_W(FRAC_W)) u_chan_g (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_pix_valid),
    .iv_fx   (tail_fx),
    .iv_fy   (tail_fy),
    .iv_c11  (iv_b11[GLsb +: GW]),
    .iv_c12  (iv_b12[GLsb +: GW]),
    .iv_c21  (iv_b21[GLsb +: GW]),
    .iv_c22  (iv_b22[GLsb +: GW]),
    .o_valid (g_valid),
    .ov_res  (g_res)
  );

  bilerp_chan #(.CHAN_W(BW), .FRAC_W(FRAC_W)) u_chan_b (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_valid (i_pix_valid),
    .iv_fx   (tail_fx),
    .iv_fy   (tail_fy),
    .iv_c11  (iv_b11[BLsb +: BW]),
    .iv_c12  (iv_b12[BLsb +: BW]),
    .iv_c21  (iv_b21[BLsb +: BW]),
    .iv_c22  (iv_b22[BLsb +: BW]),
    .o_valid (b_valid),
    .ov_res  (b_res)
  );

  // The three channel valids are identical; combining them keeps every output in use
  assign chan_valid = r_valid & g_valid & b_valid;
  assign res        = pack565(r_res, g_res, b_res);

  // Output stage next-state: pixel hold, position counters, sync and sticky error
  always_comb begin
    last_col = (col_q == iv_width - 12'd1);
    last_row = (row_q == iv_depth - 12'd1);
    col_d    = col_q;
    row_d    = row_q;
    hsyn_d   = 1'b0;
    fsyn_d   = 1'b0;
    if (chan_valid) begin
      if (last_col) begin
        col_d  = '0;
        hsyn_d = 1'b1;
        if (last_row) begin
          row_d  = '0;
          fsyn_d = 1'b1;
        end else begin
          row_d = row_q + 12'd1;
        end
      end else begin
        col_d = col_q + 12'd1;
      end
    end
    valid_d = chan_valid;
    pixel_d = chan_valid ? res : pixel_q;
    // A strobe with no matching request poisons alignment until reset
    err_d   = err_q | (i_pix_valid & ~tail_valid);
  end

  // State registers, all cleared asynchronously
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < FETCH_LAT; i++) begin
        dl_q[i] <= '0;
      end
      col_q   <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      pixel_q <= '0;
      hsyn_q  <= 1'b0;
      fsyn_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < FETCH_LAT; i++) begin
        dl_q[i] <= dl_d[i];
      end
      col_q   <= col_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      pixel_q <= pixel_d;
      hsyn_q  <= hsyn_d;
      fsyn_q  <= fsyn_d;
      err_q   <= err_d;
    end
  end

  assign o_valid     = valid_q;
  assign ov_pixel    = pixel_q;
  assign o_hsyn      = hsyn_q;
  assign o_fsyn      = fsyn_q;
  assign o_align_err = err_q;

endmodule

// File: doc/bilinear_interp.md
Name: bilinear_interp

Overview:
- Consumer end of the 2x2 neighbourhood fetch interface: receives b11/b12/b21/b22 RGB565 pixels plus valid strobe from the fetch stage.
- Produces one bilinearly interpolated RGB565 output pixel per input strobe.
- Delays the fractional weights issued with each coordinate request so they align with the fetched pixels.
- Generates output line/frame sync for the rotated-image writer downstream.

Parameters:
- FRAC_W, 8, bits of fractional weight fx/fy (weight unit = 2^FRAC_W).
- FETCH_LAT, 1, clock cycles from coordinate request to pixel-valid strobe of the fetch stage (1..8).

Ports:
- i_clk, input, 1, clock.
- i_reset, input, 1, asynchronous active-high reset.
- i_req_valid, input, 1, coordinate request issued to fetch stage this cycle.
- iv_fx, input, FRAC_W, horizontal fraction of the request (weight of b12/b22).
- iv_fy, input, FRAC_W, vertical fraction of the request (weight of b21/b22).
- i_pix_valid, input, 1, fetch-stage output strobe (its o_hsyn).
- iv_b11, iv_b12, iv_b21, iv_b22, input, 16 each, RGB565 neighbours (R[15:11] G[10:5] B[4:0]); 11 = top-left, 12 = top-right, 21 = bottom-left, 22 = bottom-right.
- iv_width, input, 12, output line length in pixels.
- iv_depth, input, 12, output frame height in lines.
- o_valid, output, 1, ov_pixel valid.
- ov_pixel, output, 16, interpolated RGB565.
- o_hsyn, output, 1, high with the last pixel of each line.
- o_fsyn, output, 1, high with the last pixel of each frame.
- o_align_err, output, 1, sticky alignment error flag.

Behaviour:
- Reset: every output 0; pipeline registers, delay line, counters and error flag cleared asynchronously. Reset mid-stream discards all in-flight pixels; counting restarts at column 0, row 0.
- Fraction delay line:
  - FETCH_LAT-deep shift of {i_req_valid, iv_fx, iv_fy}, shifting every cycle.
  - Tail entry is consumed when i_pix_valid = 1.
- Alignment check:
  - i_pix_valid = 1 while tail valid bit = 0 sets o_align_err = 1, held until reset.
  - The pixel is still processed with the tail fractions.
  - A tail valid = 1 with i_pix_valid = 0 is dropped silently.
- Per channel c (5/6/5 bits), unsigned arithmetic, 3-stage pipeline:
  - S1: top = b11.c*(2^F - fx) + b12.c*fx; bot = b21.c*(2^F - fx) + b22.c*fx. Width = chan + F + 1.
  - S2: acc = top*(2^F - fy) + bot*fy. Width = chan + 2F + 2; no truncation.
  - S3: res = (acc + 2^(2F-1)) >> 2F, saturated to channel max (31/63/31). Repack as RGB565.
- Latency: i_pix_valid in cycle N gives o_valid/ov_pixel in cycle N+3. Throughput 1 per cycle, back-to-back strobes supported. Valid bit travels with data.
- ov_pixel holds its last value while o_valid = 0.
- Counters (12-bit col, row), advanced only when o_valid = 1:
  - col == iv_width-1 (12-bit wrap, so width 0 behaves as 4096): o_hsyn = 1 and col <- 0; then if row == iv_depth-1: o_fsyn = 1 and row <- 0, else row + 1.
  - Otherwise col + 1.
  - o_hsyn and o_fsyn are registered and coincident with the qualifying o_valid.
- iv_width and iv_depth are sampled continuously; change them only between frames (behaviour on a mid-frame change is undefined).

Decomposition:
- Shared package (rot_pkg):
  - RGB565 field positions and widths.
  - FRAC_W default.
  - Coordinate width of 12.
- Sub-module bilerp_chan (parameter CHAN_W), instantiated 3 times:
  - Pure pipeline S1–S3 for one channel with valid pass-through.
- Top level holds the delay line, alignment check, counters and sync generation.

Test Plan:
- fx=0, fy=0, b11=0xF81F, others 0, one strobe -> 3 cycles later o_valid=1, ov_pixel=0xF81F.
- fx=fy=128 (F=8), b11=0xFFFF, others 0 -> ov_pixel=0x4208 (R=8, G=16, B=8, rounding checked).
- All four neighbours 0xFFFF, fx=fy=255, 64 random fraction pairs -> ov_pixel=0xFFFF every time (no overflow). Random neighbours checked against a reference model, mismatch count 0.
- iv_width=4, iv_depth=2, 8 back-to-back requests/strobes with FETCH_LAT=1 -> o_valid for 8 consecutive cycles; o_hsyn on pixels 4 and 8; o_fsyn on pixel 8 only; 9th pixel gets col 0, row 0.
- i_pix_valid pulse with no prior i_req_valid -> o_align_err=1 and stays 1; pixel still emitted 3 cycles later.
- i_reset asserted 1 cycle after a strobe burst -> all outputs 0 immediately; no o_valid from the flushed pixels after release; next frame's o_hsyn arrives after exactly iv_width pixels.
